// File: rtl/trees_pkg.sv
// Shared definitions for the trees accelerator host-side logic.
// Holds the burst controller state encoding and helpers that derive the
// prediction word count and the final-word byte mask from a burst length.
package trees_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    SETTLE,
    DRAIN,
    DONE
  } burst_ctrl_state;

  // Packed prediction words needed for len samples (8 one-byte results per word).
  function automatic logic [31:0] pred_words(input logic [31:0] len);
    return (len + 32'd7) >> 3;
  endfunction

  // Byte mask for the final prediction word; lanes past the last sample are cleared.
  function automatic logic [63:0] last_word_mask(input logic [2:0] len_lsb);
    logic [63:0] m;
    m = '0;
    if (len_lsb == 3'd0) begin
      m = '1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (3'(i) < len_lsb) m[8*i +: 8] = 8'hFF;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/trees_burst_ctrl.sv
// Host-side burst controller for the trees_ping_pong accelerator.
// Loads a burst of 64-bit feature words into accelerator feature memory,
// starts the accelerator, waits for completion, then streams the packed
// prediction memory back out with the unused tail bytes cleared.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cfg_valid, cfg_burst_len   burst request (sampled in IDLE only)
//   in_data/in_valid/in_ready  feature word stream from DMA read channel
//   out_data/out_valid/out_ready/out_last  prediction stream to DMA write channel
//   acc_*                      accelerator feature/prediction memory and control
//   busy, done, err            status
module trees_burst_ctrl
  import trees_pkg::*;
#(
  parameter int unsigned N_FEATURE = 32,
  parameter int unsigned MAX_BURST = 5000,
  localparam int unsigned LEN_W = $clog2(MAX_BURST) + 1,
  localparam int unsigned FA_W  = $clog2(MAX_BURST * N_FEATURE / 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [LEN_W-1:0] cfg_burst_len,
  input  logic [63:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [63:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             acc_start,
  output logic             acc_load_features,
  output logic [FA_W-1:0]  acc_feature_addr,
  output logic [63:0]      acc_features2,
  output logic [LEN_W-1:0] acc_burst_len,
  input  logic [63:0]      acc_prediction,
  output logic [LEN_W-1:0] acc_prediction_addr,
  input  logic             acc_done,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned HW   = N_FEATURE / 2;
  // Feature count/counter one bit wider than the address so the last word never wraps.
  localparam int unsigned FW_W = FA_W + 1;

  burst_ctrl_state state_q, state_d;

  logic [LEN_W-1:0] len_q;
  logic [FW_W-1:0]  feat_words_q;
  logic [LEN_W-1:0] pw_q;
  logic [FW_W-1:0]  fcnt_q;
  logic [LEN_W-1:0] rcnt_q;
  logic             done_q;
  logic             err_q;

  logic accept;
  logic reject;
  logic zero_len;
  logic load_hs;
  logic last_feat;
  logic drain_hs;
  logic last_pred;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and stream/control outputs
  always_comb begin
    state_d           = state_q;
    accept            = 1'b0;
    reject            = 1'b0;
    zero_len          = 1'b0;
    load_hs           = 1'b0;
    last_feat         = 1'b0;
    drain_hs          = 1'b0;
    last_pred         = 1'b0;
    in_ready          = 1'b0;
    acc_load_features = 1'b0;
    acc_features2     = '0;
    acc_start         = 1'b0;
    out_valid         = 1'b0;
    out_last          = 1'b0;
    out_data          = '0;
    busy              = (state_q != IDLE);
    done              = done_q;
    err               = err_q;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_burst_len > LEN_W'(MAX_BURST)) begin
            reject = 1'b1;
          end else if (cfg_burst_len == '0) begin
            zero_len = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        in_ready          = 1'b1;
        load_hs           = in_valid;
        acc_load_features = load_hs;
        acc_features2     = in_data;
        last_feat         = (fcnt_q == feat_words_q - FW_W'(1));
        if (load_hs && last_feat) state_d = START;
      end
      START: begin
        acc_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (acc_done) state_d = SETTLE;
      end
      // Lets the accelerator's final prediction write land before reading.
      SETTLE: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        last_pred = (rcnt_q == pw_q - LEN_W'(1));
        out_last  = last_pred;
        out_data  = last_pred ? (acc_prediction & last_word_mask(len_q[2:0]))
                              : acc_prediction;
        drain_hs  = out_ready;
        if (drain_hs && last_pred) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc_feature_addr    = fcnt_q[FA_W-1:0];
  assign acc_prediction_addr = rcnt_q;
  assign acc_burst_len       = len_q;

  // Burst length, derived word counts, counters and IDLE-side status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      feat_words_q <= '0;
      pw_q         <= '0;
      fcnt_q       <= '0;
      rcnt_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= zero_len;
      err_q  <= reject;
      if (accept) begin
        len_q        <= cfg_burst_len;
        feat_words_q <= FW_W'(cfg_burst_len) * FW_W'(HW);
        pw_q         <= LEN_W'(pred_words(32'(cfg_burst_len)));
        fcnt_q       <= '0;
        rcnt_q       <= '0;
      end
      if (load_hs && !last_feat) fcnt_q <= fcnt_q + FW_W'(1);
      if (drain_hs && !last_pred) rcnt_q <= rcnt_q + LEN_W'(1);
    end
  end

endmodule

// File: doc/trees_burst_ctrl.md
# trees_burst_ctrl

Host-side burst controller for the `trees_ping_pong` tree-ensemble accelerator. It accepts a burst length and a 64-bit feature word stream from the DMA read channel, and writes the words into the accelerator feature memory. It then pulses the accelerator start and waits for completion. Finally it reads the packed prediction memory back out as a 64-bit valid/ready stream for the DMA write channel.

## Interface
Parameters:
- `N_FEATURE`, 32: features per sample; each 64-bit word carries 2 features.
- `MAX_BURST`, 5000: maximum samples per burst.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `cfg_valid`  in  1: one-cycle request to start a burst; sampled only in IDLE.
- `cfg_burst_len`  in  $clog2(MAX_BURST)+1: number of samples in the burst.
- `in_data`  in  64: feature word stream.
- `in_valid`  in  1: feature word stream valid.
- `in_ready`  out  1: feature word stream ready.
- `out_data`  out  64: prediction word stream.
- `out_valid`  out  1: prediction word stream valid.
- `out_ready`  in  1: prediction word stream ready.
- `out_last`  out  1: marks the final prediction word.
- `acc_start`  out  1: start pulse to the accelerator.
- `acc_load_features`  out  1: feature memory write enable.
- `acc_feature_addr`  out  $clog2(MAX_BURST*N_FEATURE/2): feature memory write address.
- `acc_features2`  out  64: feature memory write data.
- `acc_burst_len`  out  $clog2(MAX_BURST)+1: burst length presented to the accelerator.
- `acc_prediction`  in  64: combinational prediction memory read data.
- `acc_prediction_addr`  out  $clog2(MAX_BURST)+1: prediction memory read address.
- `acc_done`  in  1: one-cycle completion pulse from the accelerator.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse at the end of a burst.
- `err`  out  1: one-cycle pulse when a request is rejected.

## Operation
- Derived word counts:
  - HW = N_FEATURE/2.
  - Feature words = `burst_len*HW`.
  - Prediction words PW = `ceil(burst_len/8)` = `(burst_len+7)>>3`.
  - Both computed into registers on accept, one bit wider than needed.
- **IDLE:**
  - `cfg_valid` with `cfg_burst_len > MAX_BURST` → `err` pulse next cycle, stay IDLE.
  - `cfg_valid` with `cfg_burst_len == 0` → `done` pulse next cycle; no start, no stream traffic.
  - Otherwise latch `burst_len`, clear counters, go to LOAD.
- **LOAD:**
  - `in_ready` = 1.
  - Each handshake writes the word: `acc_load_features` = `in_valid & in_ready`, `acc_features2` = `in_data`, `acc_feature_addr` = word counter (combinational from the counter).
  - After the last word → START.
- **START:** `acc_start` = 1 for exactly one cycle → WAIT.
- **WAIT:**
  - On `acc_done` → SETTLE. This state never times out.
- **SETTLE:** one cycle, so the final prediction memory write is visible → DRAIN.
- **DRAIN:**
  - `acc_prediction_addr` = read counter; `out_data` = `acc_prediction` with masking.
  - `out_valid` = 1; `out_last` = (read counter == PW-1).
  - Final word masking: when `burst_len[2:0] != 0`, byte lanes ≥ `burst_len[2:0]` are forced to 0. Lane i = bits [8i+7:8i], sample 8w+i.
  - On handshake, increment the read counter; on handshake of the last word → DONE.
- **DONE:** `done` = 1 for one cycle → IDLE.
- `acc_burst_len` = latched `burst_len`, held stable from LOAD through DONE.
- `cfg_valid` outside IDLE is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - All counters = 0; latched `burst_len` = 0.
  - Every output = 0, including `in_ready` and `out_valid`.
- Reset mid-operation returns to IDLE immediately, with no `done` and no `err`. A partly loaded burst is discarded.
- Cycle counts:
  - Request accepted at cycle 0 → `in_ready` high at cycle 1.
  - `acc_start` fires on the cycle after the last feature handshake.
  - First `out_valid` comes 2 cycles after `acc_done`.
  - `done` comes 1 cycle after the last output handshake.
- Throughput: 1 word/cycle on both streams under no backpressure.
- Input stream: `in_valid` may drop at any time; words are written only on handshake.
- Output stream:
  - `out_valid` never drops before its handshake.
  - `out_data` is stable while stalled, because the address is held.
- The feature counter reaching the maximum address (MAX_BURST*HW-1) must not wrap before the transition.

## Structure
- `trees_pkg` (shared) holds:
  - The `burst_ctrl_state` enum: IDLE, LOAD, START, WAIT, SETTLE, DRAIN, DONE.
  - Function `pred_words(len)`.
  - Function `last_word_mask(len)`, returning a 64-bit byte mask.
- No sub-module. The single FSM plus three counters (feature word, read word, latched length) fits in one file.

## Test plan
- N_FEATURE=32, `burst_len`=3:
  - 48 input words → 48 writes at addresses 0..47, then one `acc_start`.
  - After `acc_done`: one output word at address 0 with `out_last`=1; bytes 3..7 are 0 even when memory holds 0xFF there.
  - `done` follows.
- `burst_len`=16:
  - 256 writes, then 2 output words, both unmasked; `out_last` only on the second.
- Backpressure:
  - `burst_len`=9 with random `in_valid` gaps and `out_ready` low for 5 cycles on word 0.
  - `out_data` and `acc_prediction_addr` are stable while stalled; word 1 keeps only byte 0.
- Boundaries:
  - `burst_len`=0 → `done` pulse, no `acc_start`, no traffic.
  - `burst_len`=5001 → `err` pulse, `busy` stays 0.
  - `cfg_valid` while in LOAD → ignored.
- Reset:
  - `rst_n` low after 20 of 48 words in LOAD → all outputs 0 and state IDLE.
  - A new `burst_len`=1 request then completes normally with a single masked word.
